// File: rtl/data_mux_pkg.sv
// Encodings shared by the symbol multiplexer and demultiplexer so both ends agree
// on mode values, frame-sync states and default symbol format.
package data_mux_pkg;

    localparam int          DEFAULT_SYM_W       = 3;
    localparam int unsigned DEFAULT_SYNC_SYMBOL = 7;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_1   = 2'd1,
        MODE_2   = 2'd2,
        MODE_3   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        SLOT0    = 3'd1,
        SLOT1    = 3'd2,
        SLOT2    = 3'd3,
        SYNC_CHK = 3'd4
    } sync_state_t;

endpackage

// File: rtl/data_demultiplexer_if.sv
// Symbol stream in, routed channels out, plus frame-sync debug state.
// sync_err_cnt is present only when DEMUX_ERR_CNT_EN is defined.
interface data_demultiplexer_if #(
    parameter int SYM_W = data_mux_pkg::DEFAULT_SYM_W
);
    // sym_in is consumed only on cycles where sym_valid=1; there is no backpressure.
    logic [SYM_W-1:0]          sym_in;
    logic                      sym_valid;
    logic [1:0]                mode;
    logic [SYM_W-1:0]          ds1_out;
    logic [SYM_W-1:0]          ds2_out;
    logic [SYM_W-1:0]          ds3_out;
    logic                      ds1_valid;
    logic                      ds2_valid;
    logic                      ds3_valid;
    logic                      locked;
    data_mux_pkg::sync_state_t state;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0]                sync_err_cnt;
`endif

    modport master (
        output sym_in, sym_valid, mode,
        input  ds1_out, ds2_out, ds3_out,
        input  ds1_valid, ds2_valid, ds3_valid,
        input  locked, state
`ifdef DEMUX_ERR_CNT_EN
        , input sync_err_cnt
`endif
    );

    modport slave (
        input  sym_in, sym_valid, mode,
        output ds1_out, ds2_out, ds3_out,
        output ds1_valid, ds2_valid, ds3_valid,
        output locked, state
`ifdef DEMUX_ERR_CNT_EN
        , output sync_err_cnt
`endif
    );

endinterface

// File: rtl/data_demultiplexer_frame_sync.sv
// Frame-sync FSM: hunts for the sync symbol, steps through the three data slots,
// flywheels over isolated sync misses and drops lock after LOSS_THRESH in a row.
module demux_frame_sync
    import data_mux_pkg::*;
#(
    parameter int               SYM_W       = DEFAULT_SYM_W,
    parameter logic [SYM_W-1:0] SYNC_SYMBOL = SYM_W'(DEFAULT_SYNC_SYMBOL),
    parameter int               LOSS_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    input  logic [1:0]       mode,
    output sync_state_t      state,
    output logic [1:0]       slot,
    output logic             in_slot,
    output mode_t            mode_lat,
    output logic             locked
);

    localparam int CNT_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

    logic [CNT_W-1:0] miss_cnt;
    logic             sync_hit;

    assign sync_hit = (sym_in == SYNC_SYMBOL);

    always_comb begin
        slot    = 2'd0;
        in_slot = 1'b0;
        case (state)
            SLOT0: begin slot = 2'd0; in_slot = 1'b1; end
            SLOT1: begin slot = 2'd1; in_slot = 1'b1; end
            SLOT2: begin slot = 2'd2; in_slot = 1'b1; end
            default: begin slot = 2'd0; in_slot = 1'b0; end
        endcase
    end

    // Live mode==0 overrides everything, including an accepted symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            miss_cnt <= '0;
            mode_lat <= MODE_OFF;
            locked   <= 1'b0;
        end else if (mode == MODE_OFF) begin
            state    <= HUNT;
            miss_cnt <= '0;
            locked   <= 1'b0;
        end else if (sym_valid) begin
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        mode_lat <= mode_t'(mode);
                        state    <= SLOT0;
                    end
                end
                SLOT0: state <= SLOT1;
                SLOT1: state <= SLOT2;
                SLOT2: state <= SYNC_CHK;
                SYNC_CHK: begin
                    if (sync_hit) begin
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                        mode_lat <= mode_t'(mode);
                        state    <= SLOT0;
                    end else if (!locked) begin
                        state <= HUNT;
                    end else if (miss_cnt == CNT_W'(LOSS_THRESH - 1)) begin
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                        state    <= HUNT;
                    end else begin
                        // Flywheel: the missed position still counts as a frame start.
                        miss_cnt <= miss_cnt + CNT_W'(1);
                        mode_lat <= mode_t'(mode);
                        state    <= SLOT0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: rtl/data_demultiplexer.sv
// Demultiplexer top: frame sync plus slot-to-channel routing into registered outputs.
// Optional DEMUX_ERR_CNT_EN adds a saturating sync-miss counter.
module data_demultiplexer
    import data_mux_pkg::*;
#(
    parameter int               SYM_W       = DEFAULT_SYM_W,
    parameter logic [SYM_W-1:0] SYNC_SYMBOL = SYM_W'(DEFAULT_SYNC_SYMBOL),
    parameter int               LOSS_THRESH = 3
) (
    input logic               clk,
    input logic               rst_n,
    data_demultiplexer_if.slave bus
);

    sync_state_t      state;
    logic [1:0]       slot;
    logic             in_slot;
    mode_t            mode_lat;
    logic             locked;
    logic             route_en;
    logic [1:0]       ch;
    logic [SYM_W-1:0] ds1_q, ds2_q, ds3_q;
    logic             v1_q, v2_q, v3_q;

    demux_frame_sync #(
        .SYM_W       (SYM_W),
        .SYNC_SYMBOL (SYNC_SYMBOL),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_frame_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_in    (bus.sym_in),
        .sym_valid (bus.sym_valid),
        .mode      (bus.mode),
        .state     (state),
        .slot      (slot),
        .in_slot   (in_slot),
        .mode_lat  (mode_lat),
        .locked    (locked)
    );

    assign route_en = bus.sym_valid && (bus.mode != MODE_OFF) && locked && in_slot;

    always_comb begin
        ch = 2'd0;
        case (mode_lat)
            MODE_1:  ch = 2'd1;
            MODE_2:  ch = (slot == 2'd1) ? 2'd2 : 2'd1;
            MODE_3:  ch = slot + 2'd1;
            default: ch = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds1_q <= '0;
            ds2_q <= '0;
            ds3_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            if (route_en) begin
                case (ch)
                    2'd1: begin ds1_q <= bus.sym_in; v1_q <= 1'b1; end
                    2'd2: begin ds2_q <= bus.sym_in; v2_q <= 1'b1; end
                    2'd3: begin ds3_q <= bus.sym_in; v3_q <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ds1_out   = ds1_q;
    assign bus.ds2_out   = ds2_q;
    assign bus.ds3_out   = ds3_q;
    assign bus.ds1_valid = v1_q;
    assign bus.ds2_valid = v2_q;
    assign bus.ds3_valid = v3_q;
    assign bus.locked    = locked;
    assign bus.state     = state;

`ifdef DEMUX_ERR_CNT_EN
    logic       sync_miss;
    logic [7:0] err_cnt;

    // Every miss counts, locked or not; the counter sticks at 255.
    assign sync_miss = bus.sym_valid && (bus.mode != MODE_OFF) &&
                       (state == SYNC_CHK) && (bus.sym_in != SYNC_SYMBOL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (sync_miss && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.sync_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_data_demultiplexer.sv
// Bench for data_demultiplexer: directed scenarios plus random frames checked
// against a stream-level reference model; DEMUX_ERR_CNT_EN adds counter checks.
module tb_data_demultiplexer;
    import data_mux_pkg::*;

    localparam int         W      = 3;
    localparam logic [2:0] SYNC   = 3'b111;
    localparam int         THRESH = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_demultiplexer_if #(.SYM_W(W)) bus ();

    data_demultiplexer #(
        .SYM_W       (W),
        .SYNC_SYMBOL (SYNC),
        .LOSS_THRESH (THRESH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] obs_q[$];
    int           pulse_cnt[4];
    int           multi_pulse = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(bus.ds1_valid) + int'(bus.ds2_valid) + int'(bus.ds3_valid) > 1)
                multi_pulse++;
            if (bus.ds1_valid) begin obs_q.push_back({2'd1, bus.ds1_out}); pulse_cnt[1]++; end
            if (bus.ds2_valid) begin obs_q.push_back({2'd2, bus.ds2_out}); pulse_cnt[2]++; end
            if (bus.ds3_valid) begin obs_q.push_back({2'd3, bus.ds3_out}); pulse_cnt[3]++; end
        end
    end

    // ---------------- reference model ----------------
    // m_pos: -1 hunting; 1..3 next symbol is data slot m_pos-1; 0 next symbol is the sync position.
    int m_pos  = -1;
    bit m_lock = 1'b0;
    int m_miss = 0;
    int m_mode = 0;
    int m_err  = 0;

    function automatic logic [W+1:0] route(input int md, input int sl, input logic [W-1:0] s);
        logic [1:0] c;
        if (md == 1)      c = 2'd1;
        else if (md == 2) c = (sl == 1) ? 2'd2 : 2'd1;
        else              c = 2'(sl + 1);
        return {c, s};
    endfunction

    function automatic void model_step(input logic [W-1:0] s);
        int md;
        md = int'(bus.mode);
        if (md == 0) return;
        if (m_pos < 0) begin
            if (s == SYNC) begin m_pos = 1; m_mode = md; end
        end else if (m_pos > 0) begin
            if (m_lock) exp_q.push_back(route(m_mode, m_pos - 1, s));
            m_pos = (m_pos == 3) ? 0 : m_pos + 1;
        end else if (s == SYNC) begin
            m_lock = 1'b1; m_miss = 0; m_mode = md; m_pos = 1;
        end else begin
            m_err++;
            if (!m_lock) m_pos = -1;
            else begin
                m_miss++;
                if (m_miss >= THRESH) begin m_lock = 1'b0; m_miss = 0; m_pos = -1; end
                else begin m_pos = 1; m_mode = md; end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sym(input logic [W-1:0] s);
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        model_step(s);
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, c, d, input int gap);
        send_sym(a); idle(gap);
        send_sym(b); idle(gap);
        send_sym(c); idle(gap);
        send_sym(d); idle(gap);
    endtask

    task automatic set_mode(input int md);
        bus.mode = 2'(md);
        if (md == 0) begin m_pos = -1; m_lock = 1'b0; m_miss = 0; end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    endtask

    task automatic model_reset();
        m_pos = -1; m_lock = 1'b0; m_miss = 0; m_mode = 0; m_err = 0;
        exp_q.delete(); obs_q.delete(); clear_counts();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] outs[3];
        bus.sym_in = '0; bus.sym_valid = 1'b0; bus.mode = 2'd0;
        rst_n = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(2);
        outs[0] = bus.ds1_out; outs[1] = bus.ds2_out; outs[2] = bus.ds3_out;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (outs[i] !== '0) begin
                tests_failed++;
                $display("FAIL reset_ds%0d_out: got %0d want 0", i + 1, outs[i]);
            end
        end
        tests_run++;
        if ({bus.ds1_valid, bus.ds2_valid, bus.ds3_valid, bus.locked} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.ds1_valid, bus.ds2_valid, bus.ds3_valid, bus.locked});
        end
        tests_run++;
        if (bus.state !== HUNT) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want %0d", bus.state, HUNT);
        end
`ifdef DEMUX_ERR_CNT_EN
        tests_run++;
        if (bus.sync_err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_err_cnt: got %0d want 0", bus.sync_err_cnt);
        end
`endif
    endtask

    task automatic test_mode3_lock();
        set_mode(3);
        clear_counts();
        send_frame(3'd7, 3'd1, 3'd2, 3'd3, 3);
        idle(1);
        tests_run++;
        if (obs_q.size() != 0 || bus.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL m3_first_frame: got pulses=%0d locked=%b want 0 0", obs_q.size(), bus.locked);
        end
        tests_run++;
        if (bus.state !== SYNC_CHK) begin
            tests_failed++;
            $display("FAIL m3_state_before_sync: got %0d want %0d", bus.state, SYNC_CHK);
        end
        send_sym(3'd7);
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL m3_lock_rise: got %b want 1", bus.locked);
        end
        idle(3); send_sym(3'd4); idle(3); send_sym(3'd5); idle(3); send_sym(3'd6); idle(1);
        tests_run++;
        if ({bus.ds1_out, bus.ds2_out, bus.ds3_out} !== {3'd4, 3'd5, 3'd6}) begin
            tests_failed++;
            $display("FAIL m3_outputs: got %0d,%0d,%0d want 4,5,6", bus.ds1_out, bus.ds2_out, bus.ds3_out);
        end
        tests_run++;
        if (pulse_cnt[1] != 1 || pulse_cnt[2] != 1 || pulse_cnt[3] != 1) begin
            tests_failed++;
            $display("FAIL m3_pulse_counts: got %0d,%0d,%0d want 1,1,1", pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL m3_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL m3_sb_item%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mode2_routing();
        set_mode(2);
        clear_counts();
        send_frame(3'd7, 3'd1, 3'd2, 3'd3, 3);
        idle(1);
        tests_run++;
        if (pulse_cnt[1] != 2 || pulse_cnt[2] != 1 || pulse_cnt[3] != 0) begin
            tests_failed++;
            $display("FAIL m2_pulse_counts: got %0d,%0d,%0d want 2,1,0", pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        tests_run++;
        if (bus.ds1_out !== 3'd3 || bus.ds2_out !== 3'd2) begin
            tests_failed++;
            $display("FAIL m2_outputs: got ds1=%0d ds2=%0d want 3 2", bus.ds1_out, bus.ds2_out);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL m2_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL m2_sb_item%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_loss_of_lock();
        clear_counts();
        send_frame(3'd0, 3'd4, 3'd5, 3'd6, 1);
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL loss_flywheel1: got locked=%b want 1", bus.locked);
        end
        send_frame(3'd0, 3'd1, 3'd2, 3'd3, 1);
        tests_run++;
        if (bus.locked !== 1'b1 || pulse_cnt[1] + pulse_cnt[2] != 6) begin
            tests_failed++;
            $display("FAIL loss_flywheel2: got locked=%b pulses=%0d want 1 6", bus.locked, pulse_cnt[1] + pulse_cnt[2]);
        end
        send_sym(3'd0);
        tests_run++;
        if (bus.locked !== 1'b0 || bus.state !== HUNT) begin
            tests_failed++;
            $display("FAIL loss_drop: got locked=%b state=%0d want 0 %0d", bus.locked, bus.state, HUNT);
        end
        for (int k = 0; k < 3; k++) begin
            send_frame(3'd7, 3'd1, 3'd2, 3'd3, 0);
            send_sym(3'd0);
            tests_run++;
            if (bus.locked !== 1'b0 || bus.state !== HUNT) begin
                tests_failed++;
                $display("FAIL loss_no_relock%0d: got locked=%b state=%0d want 0 %0d", k, bus.locked, bus.state, HUNT);
            end
        end
        idle(1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL loss_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL loss_sb_item%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_sync_in_data();
        set_mode(3);
        send_frame(3'd7, 3'd1, 3'd1, 3'd1, 1);
        clear_counts();
        send_frame(3'd7, 3'd7, 3'd7, 3'd7, 1);
        idle(1);
        tests_run++;
        if ({bus.ds1_out, bus.ds2_out, bus.ds3_out} !== {3'd7, 3'd7, 3'd7} ||
            pulse_cnt[1] != 1 || pulse_cnt[2] != 1 || pulse_cnt[3] != 1) begin
            tests_failed++;
            $display("FAIL sync_data_route: got %0d,%0d,%0d pulses %0d,%0d,%0d want 7,7,7 1,1,1",
                     bus.ds1_out, bus.ds2_out, bus.ds3_out, pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        send_sym(3'd7);
        tests_run++;
        if (bus.locked !== 1'b1 || bus.state !== SLOT0) begin
            tests_failed++;
            $display("FAIL sync_data_align: got locked=%b state=%0d want 1 %0d", bus.locked, bus.state, SLOT0);
        end
        send_sym(3'd1); send_sym(3'd2); send_sym(3'd3);
        idle(1);
        tests_run++;
        if ({bus.ds1_out, bus.ds2_out, bus.ds3_out} !== {3'd1, 3'd2, 3'd3}) begin
            tests_failed++;
            $display("FAIL sync_data_next: got %0d,%0d,%0d want 1,2,3", bus.ds1_out, bus.ds2_out, bus.ds3_out);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mode_off();
        send_sym(3'd7);
        send_sym(3'd4);
        idle(1);
        obs_q.delete(); exp_q.delete();
        set_mode(0);
        idle(1);
        tests_run++;
        if (bus.locked !== 1'b0 || bus.state !== HUNT) begin
            tests_failed++;
            $display("FAIL off_unlock: got locked=%b state=%0d want 0 %0d", bus.locked, bus.state, HUNT);
        end
        send_sym(3'd7);
        send_sym(3'd5);
        idle(1);
        tests_run++;
        if (obs_q.size() != 0 || bus.state !== HUNT) begin
            tests_failed++;
            $display("FAIL off_no_pulses: got pulses=%0d state=%0d want 0 %0d", obs_q.size(), bus.state, HUNT);
        end
        set_mode(1);
        clear_counts();
        send_frame(3'd7, 3'd5, 3'd5, 3'd5, 2);
        send_frame(3'd7, 3'd6, 3'd6, 3'd6, 2);
        idle(1);
        tests_run++;
        if (pulse_cnt[1] != 3 || pulse_cnt[2] != 0 || pulse_cnt[3] != 0 || bus.ds1_out !== 3'd6) begin
            tests_failed++;
            $display("FAIL off_mode1: got pulses %0d,%0d,%0d ds1=%0d want 3,0,0 6",
                     pulse_cnt[1], pulse_cnt[2], pulse_cnt[3], bus.ds1_out);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL off_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL off_sb_item%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int r;
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                set_mode(0);
                idle($urandom_range(1, 2));
                set_mode($urandom_range(1, 3));
            end else if (r == 1) begin
                set_mode($urandom_range(1, 3));
            end
            if (r < 17) begin
                send_sym(SYNC);
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 9) == 0) set_mode($urandom_range(1, 3));
                    idle($urandom_range(0, 2));
                    send_sym(3'($urandom_range(0, 7)));
                end
            end else begin
                send_sym(3'($urandom_range(0, 6)));
            end
            tests_run++;
            if (bus.locked !== m_lock) begin
                tests_failed++;
                $display("FAIL rand_locked_f%0d: got %b want %b", f, bus.locked, m_lock);
            end
            idle($urandom_range(0, 2));
        end
        idle(1);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_sb_item%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
        tests_run++;
        if (multi_pulse != 0) begin
            tests_failed++;
            $display("FAIL one_pulse_per_cycle: got %0d multi-pulse cycles want 0", multi_pulse);
        end
    endtask

`ifdef DEMUX_ERR_CNT_EN
    task automatic test_err_cnt();
        tests_run++;
        if (int'(bus.sync_err_cnt) != ((m_err > 255) ? 255 : m_err)) begin
            tests_failed++;
            $display("FAIL err_cnt_partial: got %0d want %0d", bus.sync_err_cnt, (m_err > 255) ? 255 : m_err);
        end
        set_mode(1);
        repeat (300) begin
            send_sym(3'd7); send_sym(3'd0); send_sym(3'd0); send_sym(3'd0); send_sym(3'd0);
        end
        idle(1);
        tests_run++;
        if (int'(bus.sync_err_cnt) != ((m_err > 255) ? 255 : m_err)) begin
            tests_failed++;
            $display("FAIL err_cnt_saturate: got %0d want %0d", bus.sync_err_cnt, (m_err > 255) ? 255 : m_err);
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_async_reset();
        set_mode(3);
        send_frame(3'd7, 3'd1, 3'd2, 3'd3, 0);
        send_frame(3'd7, 3'd4, 3'd5, 3'd6, 0);
        send_sym(3'd7);
        send_sym(3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.ds1_out, bus.ds2_out, bus.ds3_out} !== '0 ||
            {bus.ds1_valid, bus.ds2_valid, bus.ds3_valid, bus.locked} !== 4'b0 || bus.state !== HUNT) begin
            tests_failed++;
            $display("FAIL async_reset: got ds=%0d,%0d,%0d flags=%b state=%0d want all 0 and HUNT",
                     bus.ds1_out, bus.ds2_out, bus.ds3_out,
                     {bus.ds1_valid, bus.ds2_valid, bus.ds3_valid, bus.locked}, bus.state);
        end
`ifdef DEMUX_ERR_CNT_EN
        tests_run++;
        if (bus.sync_err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset_err_cnt: got %0d want 0", bus.sync_err_cnt);
        end
`endif
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(2);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mode3_lock();
        test_mode2_routing();
        test_loss_of_lock();
        test_sync_in_data();
        test_mode_off();
        test_random();
`ifdef DEMUX_ERR_CNT_EN
        test_err_cnt();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
